// File: rtl/mempool_pkg.sv
// Shared TCDM types used by the interconnect and the per-bank arbiters.
// The bank request/response structs are the common currency between both.
package mempool_pkg;

    localparam int unsigned AddrWidth = 12;
    localparam int unsigned DataWidth = 32;
    localparam int unsigned BeWidth   = DataWidth / 8;

    typedef logic [AddrWidth-1:0] tcdm_addr_t;
    typedef logic [DataWidth-1:0] data_t;
    typedef logic [BeWidth-1:0]   be_t;

    typedef struct packed {
        logic       wen;
        tcdm_addr_t addr;
        data_t      wdata;
        be_t        be;
    } tcdm_bank_req_t;

    typedef struct packed {
        data_t rdata;
    } tcdm_bank_resp_t;

    // Index width that stays legal for a single requester.
    function automatic int unsigned id_width(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tcdm_resp_fifo.sv
// Parametric-depth response FIFO; the head is registered storage only,
// so a pushed entry becomes visible the cycle after the push.
module tcdm_resp_fifo #(
    parameter int unsigned Depth = 2,
    parameter type entry_t = logic,
    localparam int unsigned CntWidth = $clog2(Depth + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                push_i,
    input  entry_t              data_i,
    input  logic                pop_i,
    output entry_t              head_o,
    output logic                empty_o,
    output logic                full_o,
    output logic [CntWidth-1:0] count_o
);

    localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;

    entry_t              mem_q [Depth];
    logic [PtrWidth-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntWidth-1:0] count_q;

    function automatic logic [PtrWidth-1:0] wrap_inc(input logic [PtrWidth-1:0] p);
        return (32'(p) == Depth - 1) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wrap_inc(wr_ptr_q);
            end
            if (pop_i) begin
                rd_ptr_q <= wrap_inc(rd_ptr_q);
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CntWidth'(Depth));
    assign count_o = count_q;

    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push_i && full_o && !pop_i));
    a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(pop_i && empty_o));

endmodule

// File: rtl/tcdm_bank_arbiter.sv
// Round-robin arbiter sharing one single-ported TCDM bank between NumIn
// requesters, with credit-limited reads returned through a shared FIFO.
module tcdm_bank_arbiter
    import mempool_pkg::*;
#(
    parameter int unsigned NumIn     = 4,
    parameter int unsigned RespDepth = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [NumIn-1:0] req_valid_i,
    output logic [NumIn-1:0] req_ready_o,
    input  logic [NumIn-1:0] req_wen_i,
    input  tcdm_addr_t       req_addr_i  [NumIn],
    input  data_t            req_wdata_i [NumIn],
    input  be_t              req_be_i    [NumIn],
    output logic             bank_req_o,
    output logic             bank_we_o,
    output tcdm_addr_t       bank_addr_o,
    output data_t            bank_wdata_o,
    output be_t              bank_be_o,
    input  data_t            bank_rdata_i,
    output logic [NumIn-1:0] resp_valid_o,
    input  logic [NumIn-1:0] resp_ready_i,
    output data_t            resp_rdata_o
);

    localparam int unsigned IdWidth  = id_width(NumIn);
    localparam int unsigned CntWidth = $clog2(RespDepth + 1);

    typedef struct packed {
        logic [IdWidth-1:0] id;
        data_t              rdata;
    } resp_entry_t;

    // Handshakes: a request transfers in the cycle req_valid_i[i] and
    // req_ready_o[i] are both high; a response transfers when
    // resp_valid_o[i] and resp_ready_i[i] are both high. Neither side
    // needs to hold an unaccepted beat stable.

    logic [IdWidth-1:0]  ptr_q, gnt_idx, inflight_id_q;
    logic                gnt_valid, inflight_q, credit_ok;
    logic [NumIn-1:0]    eligible;
    tcdm_bank_req_t      bank_req;
    tcdm_bank_resp_t     bank_resp;
    resp_entry_t         fifo_in, fifo_head;
    logic                fifo_pop, fifo_empty, fifo_full;
    logic [CntWidth-1:0] fifo_count;

    // Credit comes from registered state only, so a pop frees it next cycle.
    assign credit_ok = (32'(fifo_count) + 32'(inflight_q)) < RespDepth;

    always_comb begin
        eligible = '0;
        for (int unsigned i = 0; i < NumIn; i++) begin
            eligible[i] = rst_ni & req_valid_i[i] & (req_wen_i[i] | credit_ok);
        end
    end

    always_comb begin
        int unsigned idx;
        idx       = 0;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int unsigned k = 0; k < NumIn; k++) begin
            idx = (32'(ptr_q) + k) % NumIn;
            if (!gnt_valid && eligible[idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = IdWidth'(idx);
            end
        end
    end

    always_comb begin
        req_ready_o = '0;
        bank_req    = '0;
        if (gnt_valid) begin
            req_ready_o[gnt_idx] = 1'b1;
            bank_req.wen   = req_wen_i[gnt_idx];
            bank_req.addr  = req_addr_i[gnt_idx];
            bank_req.wdata = req_wdata_i[gnt_idx];
            bank_req.be    = req_be_i[gnt_idx];
        end
    end

    assign bank_req_o   = gnt_valid;
    assign bank_we_o    = bank_req.wen;
    assign bank_addr_o  = bank_req.addr;
    assign bank_wdata_o = bank_req.wdata;
    assign bank_be_o    = bank_req.be;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q         <= '0;
            inflight_q    <= 1'b0;
            inflight_id_q <= '0;
        end else begin
            if (gnt_valid) begin
                ptr_q <= (32'(gnt_idx) == NumIn - 1) ? '0 : gnt_idx + 1'b1;
            end
            inflight_q    <= gnt_valid & ~bank_req.wen;
            inflight_id_q <= gnt_idx;
        end
    end

    // SRAM data is valid the cycle after the access, alongside inflight_q.
    assign bank_resp.rdata = bank_rdata_i;
    assign fifo_in.id      = inflight_id_q;
    assign fifo_in.rdata   = bank_resp.rdata;
    assign fifo_pop        = !fifo_empty && resp_ready_i[fifo_head.id];

    tcdm_resp_fifo #(
        .Depth   (RespDepth),
        .entry_t (resp_entry_t)
    ) i_resp_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (inflight_q),
        .data_i  (fifo_in),
        .pop_i   (fifo_pop),
        .head_o  (fifo_head),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .count_o (fifo_count)
    );

    always_comb begin
        resp_valid_o = '0;
        if (!fifo_empty) begin
            resp_valid_o[fifo_head.id] = 1'b1;
        end
    end

    assign resp_rdata_o = fifo_empty ? '0 : fifo_head.rdata;

    a_bank_req_matches: assert property (@(posedge clk_i) disable iff (!rst_ni)
        bank_req_o == |req_ready_o);
    a_ready_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(req_ready_o));
    a_resp_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(resp_valid_o));
    a_push_has_room: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(inflight_q && fifo_full && !fifo_pop));

endmodule

// File: tb/tb_tcdm_bank_arbiter.sv
// Bench for tcdm_bank_arbiter: directed scenarios plus random traffic, every
// cycle checked against a transaction-level model of grants and responses.
module tb_tcdm_bank_arbiter;
    import mempool_pkg::*;

    localparam int NumIn     = 4;
    localparam int RespDepth = 2;

    // Clock / reset
    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk = ~clk;

    logic [NumIn-1:0] req_valid, req_ready, req_wen, resp_valid, resp_ready;
    tcdm_addr_t       req_addr  [NumIn];
    data_t            req_wdata [NumIn];
    be_t              req_be    [NumIn];
    logic             bank_req, bank_we;
    tcdm_addr_t       bank_addr;
    data_t            bank_wdata, bank_rdata, resp_rdata;
    be_t              bank_be;

    tcdm_bank_arbiter #(.NumIn(NumIn), .RespDepth(RespDepth)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_wen_i    (req_wen),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .req_be_i     (req_be),
        .bank_req_o   (bank_req),
        .bank_we_o    (bank_we),
        .bank_addr_o  (bank_addr),
        .bank_wdata_o (bank_wdata),
        .bank_be_o    (bank_be),
        .bank_rdata_i (bank_rdata),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .resp_rdata_o (resp_rdata)
    );

    // SRAM environment: one access per cycle, read data one cycle later
    data_t sram [4096];
    initial begin
        for (int i = 0; i < 4096; i++) sram[i] = '0;
        bank_rdata = '0;
        forever begin
            @(posedge clk);
            if (bank_req) begin
                if (bank_we) begin
                    for (int b = 0; b < 4; b++)
                        if (bank_be[b]) sram[bank_addr][8*b +: 8] <= bank_wdata[8*b +: 8];
                end else begin
                    bank_rdata <= sram[bank_addr];
                end
            end
        end
    end

    // Reference model: outstanding-read credit, pending responses, memory image
    typedef struct {
        int    id;
        data_t data;
        int    vis;
    } rsp_t;
    rsp_t  m_q[$];
    data_t ref_mem [4096];
    int    m_ptr, m_out, cyc;
    int    n_vec, n_err;

    logic [NumIn-1:0] s_ready, s_resp_valid;
    logic             s_we;
    data_t            s_rdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        int   g;
        int   idx;
        bit   hv;
        logic [NumIn-1:0] exp_ready, exp_rv;
        tcdm_addr_t a;
        @(negedge clk);
        s_ready      = req_ready;
        s_resp_valid = resp_valid;
        s_we         = bank_we;
        s_rdata      = resp_rdata;
        if (!rst_ni) begin
            chk("rst_req_ready", 32'(req_ready), 0);
            chk("rst_bank_req_we", {30'b0, bank_req, bank_we}, 0);
            chk("rst_bank_addr", 32'(bank_addr), 0);
            chk("rst_bank_wdata", bank_wdata, 0);
            chk("rst_bank_be", 32'(bank_be), 0);
            chk("rst_resp_valid", 32'(resp_valid), 0);
            chk("rst_resp_rdata", resp_rdata, 0);
            m_ptr = 0;
            m_out = 0;
            m_q.delete();
        end else begin
            g = -1;
            for (int k = 0; k < NumIn; k++) begin
                idx = (m_ptr + k) % NumIn;
                if (g < 0 && req_valid[idx] && (req_wen[idx] || m_out < RespDepth)) g = idx;
            end
            exp_ready = (g >= 0) ? NumIn'(1 << g) : '0;
            chk("grant", 32'(req_ready), 32'(exp_ready));
            chk("bank_req", 32'(bank_req), (g >= 0) ? 1 : 0);
            if (g >= 0) begin
                chk("bank_we", 32'(bank_we), 32'(req_wen[g]));
                chk("bank_addr", 32'(bank_addr), 32'(req_addr[g]));
                if (req_wen[g]) begin
                    chk("bank_wdata", bank_wdata, req_wdata[g]);
                    chk("bank_be", 32'(bank_be), 32'(req_be[g]));
                end
            end
            hv = (m_q.size() > 0) && (m_q[0].vis <= cyc);
            exp_rv = hv ? NumIn'(1 << m_q[0].id) : '0;
            chk("resp_valid", 32'(resp_valid), 32'(exp_rv));
            if (hv) chk("resp_rdata", resp_rdata, m_q[0].data);
            if (hv && resp_ready[m_q[0].id]) begin
                void'(m_q.pop_front());
                m_out--;
            end
            if (g >= 0) begin
                a = req_addr[g];
                if (req_wen[g]) begin
                    for (int b = 0; b < 4; b++)
                        if (req_be[g][b]) ref_mem[a][8*b +: 8] = req_wdata[g][8*b +: 8];
                end else begin
                    m_q.push_back('{g, ref_mem[a], cyc + 2});
                    m_out++;
                end
                m_ptr = (g + 1) % NumIn;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    // Driver tasks
    task automatic idle();
        req_valid = '0;
    endtask

    task automatic set_req(input int i, input logic wen, input tcdm_addr_t a,
                           input data_t d, input be_t be);
        req_valid[i] = 1'b1;
        req_wen[i]   = wen;
        req_addr[i]  = a;
        req_wdata[i] = d;
        req_be[i]    = be;
    endtask

    initial begin
        n_vec = 0; n_err = 0; cyc = 0; m_ptr = 0; m_out = 0;
        for (int i = 0; i < 4096; i++) ref_mem[i] = '0;
        req_valid = '0; req_wen = '0; resp_ready = '1;
        for (int i = 0; i < NumIn; i++) begin
            req_addr[i] = '0; req_wdata[i] = '0; req_be[i] = '0;
        end

        // Reset with all requesters asking, then round-robin writes
        for (int i = 0; i < NumIn; i++) set_req(i, 1'b1, tcdm_addr_t'(32 + i), 32'h1000_0000 + i, 4'hF);
        step(); step();
        rst_ni = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            chk("rr_seq", 32'(s_ready), 32'(1 << (k % 4)));
            chk("rr_we", 32'(s_we), 1);
        end
        idle();

        // Read return latency
        set_req(2, 1'b1, 12'h0A5, 32'hDEAD_BEEF, 4'hF);
        step();
        idle();
        set_req(2, 1'b0, 12'h0A5, '0, 4'hF);
        step();
        chk("rd_grant", 32'(s_ready), 32'b0100);
        idle();
        step();
        chk("rd_not_early", 32'(s_resp_valid), 0);
        step();
        chk("rd_valid_t2", 32'(s_resp_valid), 32'b0100);
        chk("rd_data", s_rdata, 32'hDEAD_BEEF);
        step();

        // Credit stall with responses back-pressured
        resp_ready = '0;
        set_req(1, 1'b0, 12'h020, '0, 4'hF); step(); chk("cr_g1", 32'(s_ready), 32'b0010);
        set_req(1, 1'b0, 12'h021, '0, 4'hF); step(); chk("cr_g2", 32'(s_ready), 32'b0010);
        set_req(1, 1'b0, 12'h022, '0, 4'hF); step(); chk("cr_stall", 32'(s_ready), 0);
        step(); chk("cr_stall2", 32'(s_ready), 0);
        resp_ready = 4'b0010;
        step(); chk("cr_pop_cycle", 32'(s_ready), 0);
        step(); chk("cr_g3", 32'(s_ready), 32'b0010);
        idle();
        for (int k = 0; k < 4; k++) step();

        // Writes bypass a read stall
        resp_ready = '0;
        set_req(0, 1'b0, 12'h021, '0, 4'hF); step();
        set_req(0, 1'b0, 12'h022, '0, 4'hF); step();
        set_req(3, 1'b1, 12'h030, 32'hCAFE_F00D, 4'h5);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("wr_bypass", 32'(s_ready), 32'b1000);
        end
        resp_ready = '1;
        step(); chk("wr_bypass_pop", 32'(s_ready), 32'b1000);
        step(); chk("rd_after_credit", 32'(s_ready), 32'b0001);
        idle();
        for (int k = 0; k < 4; k++) step();

        // Reset the cycle after a read grant
        set_req(1, 1'b0, 12'h0A5, '0, 4'hF);
        step();
        idle();
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("no_stale_resp", 32'(s_resp_valid), 0);
        end
        set_req(1, 1'b0, 12'h0A5, '0, 4'hF);
        step();
        idle();
        step();
        step();
        chk("post_rst_valid", 32'(s_resp_valid), 32'b0010);
        chk("post_rst_data", s_rdata, 32'hDEAD_BEEF);

        // Random traffic, including one mid-stream reset
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NumIn; i++) begin
                req_valid[i] = 1'($urandom);
                req_wen[i]   = 1'($urandom);
                req_addr[i]  = tcdm_addr_t'($urandom_range(0, 15));
                req_wdata[i] = $urandom;
                req_be[i]    = be_t'($urandom_range(0, 15));
            end
            resp_ready = NumIn'($urandom_range(0, 15) | (($urandom_range(0, 3) == 0) ? 0 : 15));
            rst_ni = !(n == 200 || n == 201);
            step();
        end
        rst_ni = 1'b1;
        idle();
        resp_ready = '1;
        for (int k = 0; k < 6; k++) step();
        chk("drained", 32'(m_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
